xnor3_pattern_checker: RTL and testbench
========================================

XNOR3_PATTERN_CHECKER -- requirements
Module: xnor3_pattern_checker

Interface
REQ-001 SHALL have parameter DWELL, default 4, number of cycles each input vector is driven before the DUT output is sampled (legal range 1..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  one-cycle request to run a full exhaustive pass.
REQ-005 SHALL have port dut_out  input  1  output of the 3-input XNOR gate under test.
REQ-006 SHALL have ports a, b, c  output  1 each  stimulus driven to the gate under test.
REQ-007 SHALL have port busy  output  1  high while a pass is in progress.
REQ-008 SHALL have port done  output  1  high once a pass has completed; held until the next start or reset.
REQ-009 SHALL have port pass  output  1  high with done when no mismatches were recorded.
REQ-010 SHALL have port err_cnt  output  4  number of mismatching vectors in the current or last pass (0..8).
REQ-011 SHALL have port fail_vec  output  3  index {a,b,c} of the first mismatching vector; meaningful only when err_cnt != 0.

Function
REQ-012 SHALL implement FSM states IDLE, DRIVE, SAMPLE, DONE, with a 3-bit vector index vec and a dwell counter of at least 8 bits.
REQ-013 SHALL, in IDLE, drive {a,b,c}=000 with busy=0, and move to DRIVE on start=1, clearing vec, dwell counter, err_cnt, fail_vec, done and pass.
REQ-014 SHALL, in DRIVE and SAMPLE, drive {a,b,c}=vec with a as MSB and busy=1.
REQ-015 SHALL stay in DRIVE for exactly DWELL cycles (counter 0..DWELL-1), then move to SAMPLE.
REQ-016 SHALL, in SAMPLE (exactly one cycle), compare dut_out with expected = NOT(a XOR b XOR c); on mismatch, increment err_cnt and, if err_cnt was 0, load fail_vec with vec.
REQ-017 SHALL, leaving SAMPLE, move to DONE if vec==7, else increment vec, clear the dwell counter and return to DRIVE; vec SHALL NOT wrap within a pass.
REQ-018 SHALL, in DONE, drive {a,b,c}=000, busy=0, done=1, and pass=1 if err_cnt==0, else 0; err_cnt and fail_vec SHALL hold.
REQ-019 SHALL, on start=1 in DONE, begin a new pass exactly as from IDLE (clear results, go to DRIVE).
REQ-020 SHALL ignore start while in DRIVE or SAMPLE.
REQ-021 SHALL make done first visible 8*(DWELL+1) cycles after the edge that samples start (40 cycles for DWELL=4).
REQ-022 SHALL register all outputs; dut_out SHALL be sampled only in SAMPLE, with no combinational path from dut_out to any output.

Reset
REQ-023 SHALL, while rst=1, immediately force state=IDLE, {a,b,c}=000, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0, vec=0 and the dwell counter to 0, regardless of clk.
REQ-024 SHALL abandon any pass in progress when rst asserts mid-run, with no partial results retained; the next start SHALL run a full 8-vector pass.

Verification
REQ-025 Correct XNOR model on dut_out, DWELL=4, start pulse -> {a,b,c} steps 000..111, each held 5 cycles; done=1 at cycle 40; pass=1; err_cnt=0.
REQ-026 dut_out stuck at 0 -> done with pass=0, err_cnt=4, fail_vec=000.
REQ-027 dut_out stuck at 1 -> pass=0, err_cnt=4, fail_vec=001; XOR instead of XNOR -> err_cnt=8, fail_vec=000.
REQ-028 rst asserted during the vector-5 dwell -> outputs zero asynchronously (before the next clk edge); a new start then gives a full 40-cycle pass with correct results.
REQ-029 start pulsed during the vector-3 dwell -> no effect on sequence or timing; start in DONE after a failing pass -> err_cnt, fail_vec, done and pass clear on the next edge, and the new pass completes 40 cycles later.
REQ-030 DWELL=1 with correct model -> each vector held 2 cycles; done at cycle 16; pass=1.

Source files
------------

// File: rtl/xnor3_pattern_checker.sv
// xnor3_pattern_checker
// Exhaustive tester for a 3-input XNOR gate. On a start request it walks
// {a,b,c} through 000..111, holds each vector for DWELL cycles, samples the
// gate output for one cycle and records the number of mismatching vectors
// and the index of the first one.
//
// Handshake: start is a level sampled on each rising edge; it is acted on
// only in IDLE or DONE (ignored while a pass runs). busy is high from the
// edge that accepts start until the edge that enters DONE; done/pass then
// hold until the next accepted start or reset.
//
// All outputs come from registers loaded with values decoded from the
// next state, so they change on the same edge as the state and dut_out
// has no combinational path to any output.
module xnor3_pattern_checker #(
   parameter int DWELL = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       dut_out,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_cnt,
   output logic [2:0] fail_vec
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DRIVE  = 2'd1,
      S_SAMPLE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

   state_t     r_state;
   state_t     w_next;
   logic [2:0] r_vec;
   logic [7:0] r_dwell;
   logic [3:0] r_err_cnt;
   logic [2:0] r_fail_vec;
   logic [2:0] r_abc;
   logic       r_busy;
   logic       r_done;
   logic       r_pass;

   logic       w_start_pass;
   logic       w_mismatch;
   logic [2:0] w_vec_next;
   logic [3:0] w_err_next;
   logic [2:0] w_abc_next;
   logic       w_busy_next;
   logic       w_done_next;
   logic       w_pass_next;

   // start only counts when no pass is running
   assign w_start_pass = start && ((r_state == S_IDLE) || (r_state == S_DONE));

   // gate output differs from the XNOR of the vector currently applied
   assign w_mismatch = (r_state == S_SAMPLE) && (dut_out != ~^r_vec);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state decode
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (start) w_next = S_DRIVE;
         S_DRIVE:  if (r_dwell == DWELL_LAST) w_next = S_SAMPLE;
         S_SAMPLE: w_next = (r_vec == 3'd7) ? S_DONE : S_DRIVE;
         S_DONE:   if (start) w_next = S_DRIVE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Next values of the vector index and error count, shared by the
   // datapath registers and the registered output decode
   always_comb begin
      w_vec_next = r_vec;
      w_err_next = r_err_cnt;
      if (w_start_pass) begin
         w_vec_next = 3'd0;
         w_err_next = 4'd0;
      end else if (r_state == S_SAMPLE) begin
         if (r_vec != 3'd7) w_vec_next = r_vec + 3'd1;
         if (w_mismatch)    w_err_next = r_err_cnt + 4'd1;
      end
   end

   // Output decode from the next state
   always_comb begin
      w_abc_next  = 3'd0;
      w_busy_next = 1'b0;
      w_done_next = 1'b0;
      w_pass_next = 1'b0;
      case (w_next)
         S_DRIVE, S_SAMPLE: begin
            w_abc_next  = w_vec_next;
            w_busy_next = 1'b1;
         end
         S_DONE: begin
            w_done_next = 1'b1;
            w_pass_next = (w_err_next == 4'd0);
         end
         default: ;
      endcase
   end

   // Vector index, dwell counter and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vec      <= 3'd0;
         r_dwell    <= 8'd0;
         r_err_cnt  <= 4'd0;
         r_fail_vec <= 3'd0;
      end else begin
         r_vec     <= w_vec_next;
         r_err_cnt <= w_err_next;
         if (w_start_pass) begin
            r_dwell    <= 8'd0;
            r_fail_vec <= 3'd0;
         end else if (r_state == S_DRIVE) begin
            r_dwell <= (r_dwell == DWELL_LAST) ? 8'd0 : r_dwell + 8'd1;
         end else if (r_state == S_SAMPLE) begin
            r_dwell <= 8'd0;
            if (w_mismatch && (r_err_cnt == 4'd0)) r_fail_vec <= r_vec;
         end
      end
   end

   // Registered stimulus and status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_abc  <= 3'd0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_pass <= 1'b0;
      end else begin
         r_abc  <= w_abc_next;
         r_busy <= w_busy_next;
         r_done <= w_done_next;
         r_pass <= w_pass_next;
      end
   end

   assign a        = r_abc[2];
   assign b        = r_abc[1];
   assign c        = r_abc[0];
   assign busy     = r_busy;
   assign done     = r_done;
   assign pass     = r_pass;
   assign err_cnt  = r_err_cnt;
   assign fail_vec = r_fail_vec;

endmodule

// File: tb/tb_xnor3_pattern_checker.sv
// Bench for xnor3_pattern_checker: two instances (DWELL=4 and DWELL=1)
// each drive a modelled gate whose truth table the bench chooses per pass.
// Expected values come from counting mismatches of that truth table
// against the XNOR parity rule and from the per-vector cycle budget.
module tb_xnor3_pattern_checker;

   logic        clk;
   logic        rst;
   logic [1:0]  start;
   logic [7:0]  tt [2];
   logic [12:0] obs [2];

   logic        a0, b0, c0, busy0, done0, pass0;
   logic [3:0]  err0;
   logic [2:0]  fail0;
   logic        a1, b1, c1, busy1, done1, pass1;
   logic [3:0]  err1;
   logic [2:0]  fail1;
   logic        dut_out0, dut_out1;
   logic [2:0]  abc0, abc1;

   int n_vec;
   int n_err;

   assign abc0     = {a0, b0, c0};
   assign abc1     = {a1, b1, c1};
   assign dut_out0 = tt[0][abc0];
   assign dut_out1 = tt[1][abc1];
   assign obs[0]   = {busy0, done0, pass0, err0, fail0, abc0};
   assign obs[1]   = {busy1, done1, pass1, err1, fail1, abc1};

   xnor3_pattern_checker #(.DWELL(4)) u_dut4 (
      .clk(clk), .rst(rst), .start(start[0]), .dut_out(dut_out0),
      .a(a0), .b(b0), .c(c0), .busy(busy0), .done(done0), .pass(pass0),
      .err_cnt(err0), .fail_vec(fail0)
   );

   xnor3_pattern_checker #(.DWELL(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start[1]), .dut_out(dut_out1),
      .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
      .err_cnt(err1), .fail_vec(fail1)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---- reference model ----
   // an XNOR of three inputs is 1 when the number of ones is even
   function automatic bit ref_mis(input logic [7:0] t, input int v);
      bit want;
      want = (($countones(v) % 2) == 0);
      return t[v] != want;
   endfunction

   function automatic int ref_errs(input logic [7:0] t, input int nvec);
      int n;
      n = 0;
      for (int v = 0; v < nvec; v++) if (ref_mis(t, v)) n++;
      return n;
   endfunction

   function automatic int ref_first(input logic [7:0] t);
      for (int v = 0; v < 8; v++) if (ref_mis(t, v)) return v;
      return 0;
   endfunction

   function automatic logic [12:0] pk(input bit bsy, input bit dn, input bit ps,
                                      input int e, input int f, input int abc);
      return {bsy, dn, ps, 4'(e), 3'(f), 3'(abc)};
   endfunction

   // Run one pass on instance inst with gate table tbl. inj_k >= 1 pulses
   // start before edge inj_k; rst_k >= 1 aborts with reset before edge rst_k.
   task automatic run_pass(input int inst, input logic [7:0] tbl,
                           input int inj_k, input int rst_k);
      int d, total, e, f, nv;
      logic [12:0] exp_v;
      d     = (inst == 0) ? 4 : 1;
      total = 8 * (d + 1);
      tt[inst] = tbl;
      @(negedge clk);
      start[inst] = 1'b1;
      @(posedge clk);
      #1;
      start[inst] = 1'b0;
      check_eq("start_accept", obs[inst], pk(1, 0, 0, 0, 0, 0));
      for (int k = 1; k <= total; k++) begin
         @(negedge clk);
         start[inst] = (k == inj_k);
         if (k == rst_k) begin
            #2;
            rst = 1'b1;
            #1;
            check_eq("async_rst_i0", obs[0], 0);
            check_eq("async_rst_i1", obs[1], 0);
            rst = 1'b0;
            start[inst] = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
         if (k < total) begin
            nv = k / (d + 1);
            e  = ref_errs(tbl, nv);
            f  = (e != 0) ? ref_first(tbl) : 0;
            exp_v = pk(1, 0, 0, e, f, nv);
            check_eq("running", obs[inst], exp_v);
         end else begin
            e = ref_errs(tbl, 8);
            f = (e != 0) ? ref_first(tbl) : 0;
            exp_v = pk(0, 1, (e == 0), e, f, 0);
            check_eq("done_at_budget", obs[inst], exp_v);
         end
      end
      start[inst] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("done_hold", obs[inst], exp_v);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst   = 1'b1;
      start = 2'b00;
      tt[0] = 8'h69;
      tt[1] = 8'h69;
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset_i0", obs[0], 0);
      check_eq("reset_i1", obs[1], 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_eq("idle_i0", obs[0], 0);

      // directed: correct gate, stuck-at-0, stuck-at-1, XOR gate
      run_pass(0, 8'h69, -1, -1);
      run_pass(0, 8'h00, -1, -1);
      run_pass(0, 8'hFF, -1, -1);
      run_pass(0, 8'h96, -1, -1);
      // start inside the vector-3 dwell, launched from DONE after a failing pass
      run_pass(0, 8'h69, 3 * 5 + 2, -1);
      // reset inside the vector-5 dwell, then a clean full pass
      run_pass(0, 8'h00, -1, 5 * 5 + 1);
      run_pass(0, 8'h69, -1, -1);
      // short dwell instance
      run_pass(1, 8'h69, -1, -1);
      run_pass(1, 8'h96, -1, -1);
      run_pass(1, 8'h69, 3 * 2 + 1, -1);
      run_pass(1, 8'hFF, -1, 5 * 2 + 1);
      run_pass(1, 8'h69, -1, -1);

      // randomized truth tables and stray start pulses
      for (int i = 0; i < 24; i++) begin
         int inst, d, inj, rk;
         logic [7:0] tbl;
         inst = $urandom_range(0, 1);
         d    = (inst == 0) ? 4 : 1;
         tbl  = ($urandom_range(0, 3) == 0) ? 8'h69 : 8'($urandom);
         inj  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 8 * (d + 1) - 1) : -1;
         rk   = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 8 * (d + 1) - 1) : -1;
         run_pass(inst, tbl, inj, rk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
